// File: rtl/rtc_init_seq.sv
// RTC power-up initialization sequencer: walks a fixed register table and issues one bus write per entry.
// Build option: define RTC_CLEAR_TIME_EN to append six time-register clears (0x21..0x26 <= 0x00).
module rtc_init_seq #(
    parameter int TIMEOUT = 64,
    parameter int GAP     = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       cyc_done,
    output logic       cyc_en,
    output logic [7:0] cyc_addr,
    output logic [7:0] cyc_data,
    output logic       busy,
    output logic       init_done,
    output logic       err,
    output logic [3:0] idx,
    output logic [2:0] stateDbg
);

    // Write handshake: cyc_en rises with cyc_addr/cyc_data already stable and stays high
    // until the generator returns a single-clock cyc_done (accepted only in sWait) or the
    // wait budget runs out; cyc_en is then dropped on the same edge that leaves sWait.

    typedef enum logic [2:0] {
        sIdle  = 3'd0,
        sLoad  = 3'd1,
        sIssue = 3'd2,
        sWait  = 3'd3,
        sGap   = 3'd4,
        sDone  = 3'd5,
        sErr   = 3'd6
    } stateT;

`ifdef RTC_CLEAR_TIME_EN
    localparam logic [3:0] LAST_IDX = 4'd9;
`else
    localparam logic [3:0] LAST_IDX = 4'd3;
`endif
    localparam logic [7:0] TO_LAST  = 8'(TIMEOUT - 1);
    localparam logic [3:0] GAP_LAST = 4'(GAP - 1);

    stateT      state, stateNext;
    logic [7:0] toCnt, toCntNext;
    logic [3:0] gapCnt, gapCntNext;
    logic [3:0] idxNext;
    logic       cycEnNext;
    logic [7:0] addrNext, dataNext;
    logic       initDoneNext, errNext;
    logic [15:0] entry;

    // Table entry as {address, data}.
    function automatic logic [15:0] tableEntry(input logic [3:0] i);
        logic [15:0] e;
        case (i)
            4'd0:    e = 16'h0210;
            4'd1:    e = 16'h0200;
            4'd2:    e = 16'h10D2;
            4'd3:    e = 16'h0000;
`ifdef RTC_CLEAR_TIME_EN
            4'd4:    e = 16'h2100;
            4'd5:    e = 16'h2200;
            4'd6:    e = 16'h2300;
            4'd7:    e = 16'h2400;
            4'd8:    e = 16'h2500;
            4'd9:    e = 16'h2600;
`endif
            default: e = 16'h0000;
        endcase
        return e;
    endfunction

    assign entry    = tableEntry(idx);
    assign busy     = (state == sLoad) || (state == sIssue) ||
                      (state == sWait) || (state == sGap);
    assign stateDbg = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= sIdle;
            toCnt     <= 8'd0;
            gapCnt    <= 4'd0;
            idx       <= 4'd0;
            cyc_en    <= 1'b0;
            cyc_addr  <= 8'd0;
            cyc_data  <= 8'd0;
            init_done <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= stateNext;
            toCnt     <= toCntNext;
            gapCnt    <= gapCntNext;
            idx       <= idxNext;
            cyc_en    <= cycEnNext;
            cyc_addr  <= addrNext;
            cyc_data  <= dataNext;
            init_done <= initDoneNext;
            err       <= errNext;
        end
    end

    always_comb begin
        stateNext    = state;
        toCntNext    = toCnt;
        gapCntNext   = gapCnt;
        idxNext      = idx;
        cycEnNext    = cyc_en;
        addrNext     = cyc_addr;
        dataNext     = cyc_data;
        initDoneNext = init_done;
        errNext      = err;

        case (state)
            sIdle, sDone, sErr: begin
                if (start) begin
                    stateNext    = sLoad;
                    idxNext      = 4'd0;
                    initDoneNext = 1'b0;
                    errNext      = 1'b0;
                end
            end
            sLoad: begin
                addrNext  = entry[15:8];
                dataNext  = entry[7:0];
                stateNext = sIssue;
            end
            sIssue: begin
                cycEnNext = 1'b1;
                toCntNext = 8'd0;
                stateNext = sWait;
            end
            sWait: begin
                // A completion on the limit clock still counts as success.
                if (cyc_done) begin
                    cycEnNext  = 1'b0;
                    gapCntNext = 4'd0;
                    stateNext  = sGap;
                end else if (toCnt == TO_LAST) begin
                    cycEnNext = 1'b0;
                    errNext   = 1'b1;
                    stateNext = sErr;
                end else begin
                    toCntNext = toCnt + 8'd1;
                end
            end
            sGap: begin
                if (gapCnt == GAP_LAST) begin
                    if (idx == LAST_IDX) begin
                        initDoneNext = 1'b1;
                        stateNext    = sDone;
                    end else begin
                        idxNext   = idx + 4'd1;
                        stateNext = sLoad;
                    end
                end else begin
                    gapCntNext = gapCnt + 4'd1;
                end
            end
            default: begin
                cycEnNext = 1'b0;
                stateNext = sIdle;
            end
        endcase
    end

endmodule

// File: tb/tb_rtc_init_seq.sv
// Directed bench for rtc_init_seq: full runs, timeout abort, boundary completion, ignored start, mid-run reset.
// Honors RTC_CLEAR_TIME_EN to expect the extended table.
module tb_rtc_init_seq;

    localparam int TO = 64;
    localparam int GP = 2;

    logic       clk;
    logic       reset;
    logic       start;
    logic       cyc_done;
    logic       cyc_en;
    logic [7:0] cyc_addr;
    logic [7:0] cyc_data;
    logic       busy;
    logic       init_done;
    logic       err;
    logic [3:0] idx;
    logic [2:0] stateDbg;

    int total = 0;
    int bad   = 0;
    logic [15:0] exp_q[$];

    rtc_init_seq #(.TIMEOUT(TO), .GAP(GP)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .cyc_done  (cyc_done),
        .cyc_en    (cyc_en),
        .cyc_addr  (cyc_addr),
        .cyc_data  (cyc_data),
        .busy      (busy),
        .init_done (init_done),
        .err       (err),
        .idx       (idx),
        .stateDbg  (stateDbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic pulseStart();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // One table write: wait for cyc_en, hold cyc_done off for delay clocks, then time the gap.
    task automatic doWrite(input int delay, input int startAt, input logic [15:0] ent, input string tag);
        int g;
        g = 0;
        while (cyc_en !== 1'b1 && g < 20) begin
            step();
            g++;
        end
        chk({tag, " en_rise"}, 32'(cyc_en), 32'd1);
        chk({tag, " addr"}, 32'(cyc_addr), 32'(ent[15:8]));
        chk({tag, " data"}, 32'(cyc_data), 32'(ent[7:0]));
        chk({tag, " busy"}, 32'(busy), 32'd1);
        for (int k = 1; k < delay; k++) begin
            if (k == startAt) start = 1'b1;
            step();
            start = 1'b0;
            chk({tag, " hold"}, 32'({cyc_en, cyc_addr, cyc_data}), 32'({1'b1, ent}));
        end
        cyc_done = 1'b1;
        step();
        cyc_done = 1'b0;
        g = 0;
        while (stateDbg == 3'd4 && g < 20) begin
            chk({tag, " gap_en"}, 32'(cyc_en), 32'd0);
            g++;
            step();
        end
        chk({tag, " gap_len"}, 32'(g), 32'(GP));
    endtask

    initial begin
        int n;
        int lastIdx;
        reset    = 1'b0;
        start    = 1'b0;
        cyc_done = 1'b0;
        exp_q = '{16'h0210, 16'h0200, 16'h10D2, 16'h0000};
`ifdef RTC_CLEAR_TIME_EN
        exp_q.push_back(16'h2100);
        exp_q.push_back(16'h2200);
        exp_q.push_back(16'h2300);
        exp_q.push_back(16'h2400);
        exp_q.push_back(16'h2500);
        exp_q.push_back(16'h2600);
`endif
        lastIdx = exp_q.size() - 1;

        // Reset values
        #2;
        chk("rst state", 32'(stateDbg), 32'd0);
        chk("rst cyc_en", 32'(cyc_en), 32'd0);
        chk("rst addr", 32'(cyc_addr), 32'd0);
        chk("rst data", 32'(cyc_data), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst init_done", 32'(init_done), 32'd0);
        chk("rst err", 32'(err), 32'd0);
        chk("rst idx", 32'(idx), 32'd0);
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b1;
        step();

        // Stray cyc_done in IDLE does nothing
        cyc_done = 1'b1;
        step();
        cyc_done = 1'b0;
        chk("idle done_ignored state", 32'(stateDbg), 32'd0);
        chk("idle done_ignored busy", 32'(busy), 32'd0);

        // Full run, cyc_done 5 clocks after each cyc_en rise
        pulseStart();
        chk("t1 load state", 32'(stateDbg), 32'd1);
        chk("t1 load busy", 32'(busy), 32'd1);
        chk("t1 load en", 32'(cyc_en), 32'd0);
        step();
        chk("t1 issue state", 32'(stateDbg), 32'd2);
        chk("t1 issue en", 32'(cyc_en), 32'd0);
        chk("t1 issue addr", 32'(cyc_addr), 32'h02);
        chk("t1 issue data", 32'(cyc_data), 32'h10);
        step();
        chk("t1 en_latency", 32'(cyc_en), 32'd1);
        for (int i = 0; i < exp_q.size(); i++)
            doWrite(5, -1, exp_q[i], $sformatf("t1w%0d", i));
        chk("t1 init_done", 32'(init_done), 32'd1);
        chk("t1 busy", 32'(busy), 32'd0);
        chk("t1 err", 32'(err), 32'd0);
        chk("t1 cyc_en", 32'(cyc_en), 32'd0);
        chk("t1 idx", 32'(idx), 32'(lastIdx));
        chk("t1 state", 32'(stateDbg), 32'd5);

        // No cyc_done: abort after TO clocks of cyc_en
        pulseStart();
        chk("t2 init_cleared", 32'(init_done), 32'd0);
        n = 0;
        while (cyc_en !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        n = 0;
        while (cyc_en === 1'b1 && n < 200) begin
            n++;
            step();
        end
        chk("t2 en_high_len", 32'(n), 32'(TO));
        chk("t2 err", 32'(err), 32'd1);
        chk("t2 busy", 32'(busy), 32'd0);
        chk("t2 cyc_en", 32'(cyc_en), 32'd0);
        chk("t2 idx", 32'(idx), 32'd0);
        chk("t2 state", 32'(stateDbg), 32'd6);

        // cyc_done on the limit clock wins over timeout
        pulseStart();
        chk("t3 err_cleared", 32'(err), 32'd0);
        doWrite(TO, -1, exp_q[0], "t3w0");
        chk("t3 err_after_limit", 32'(err), 32'd0);
        for (int i = 1; i < exp_q.size(); i++)
            doWrite(1 + (i % 3), -1, exp_q[i], $sformatf("t3w%0d", i));
        chk("t3 init_done", 32'(init_done), 32'd1);
        chk("t3 err", 32'(err), 32'd0);

        // start during the third write is ignored
        pulseStart();
        for (int i = 0; i < exp_q.size(); i++)
            doWrite(3, (i == 2) ? 2 : -1, exp_q[i], $sformatf("t4w%0d", i));
        chk("t4 init_done", 32'(init_done), 32'd1);
        chk("t4 idx", 32'(idx), 32'(lastIdx));
        n = 0;
        repeat (10) begin
            step();
            if (cyc_en === 1'b1) n++;
        end
        chk("t4 no_extra_write", 32'(n), 32'd0);
        chk("t4 state", 32'(stateDbg), 32'd5);

        // Reset during WAIT of idx=1
        pulseStart();
        doWrite(4, -1, exp_q[0], "t5w0");
        n = 0;
        while (cyc_en !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk("t5 idx_before", 32'(idx), 32'd1);
        step();
        step();
        reset = 1'b0;
        #1;
        chk("t5 rst cyc_en", 32'(cyc_en), 32'd0);
        chk("t5 rst busy", 32'(busy), 32'd0);
        chk("t5 rst idx", 32'(idx), 32'd0);
        chk("t5 rst addr", 32'(cyc_addr), 32'd0);
        chk("t5 rst data", 32'(cyc_data), 32'd0);
        chk("t5 rst init_done", 32'(init_done), 32'd0);
        chk("t5 rst err", 32'(err), 32'd0);
        chk("t5 rst state", 32'(stateDbg), 32'd0);
        #2;
        reset = 1'b1;
        n = 0;
        repeat (5) begin
            step();
            if (cyc_en === 1'b1) n++;
        end
        chk("t5 no_resume", 32'(n), 32'd0);
        chk("t5 idle", 32'(stateDbg), 32'd0);
        pulseStart();
        step();
        chk("t5 restart addr", 32'(cyc_addr), 32'h02);
        chk("t5 restart data", 32'(cyc_data), 32'h10);
        chk("t5 restart idx", 32'(idx), 32'd0);
        for (int i = 0; i < exp_q.size(); i++)
            doWrite(2, -1, exp_q[i], $sformatf("t5w%0d", i));
        chk("t5 init_done", 32'(init_done), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rtc_init_seq.md
RTC_INIT_SEQ -- requirements
Module: rtc_init_seq

Interface
REQ-001 Parameter TIMEOUT, default 64, meaning the maximum number of clocks to wait for cyc_done per write (legal range 2..255).
REQ-002 Parameter GAP, default 2, meaning the number of idle clocks with cyc_en low between consecutive writes (legal range 1..15).
REQ-003 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port start, input, 1 bit: a one-clock pulse that requests an initialization run.
REQ-006 Port cyc_done, input, 1 bit: a one-clock pulse from the bus write-cycle generator marking the end of a write cycle.
REQ-007 Port cyc_en, output, 1 bit: enable to the write-cycle generator, held high for the whole cycle.
REQ-008 Port cyc_addr, output, 8 bits: RTC register address for the current write.
REQ-009 Port cyc_data, output, 8 bits: data byte for the current write.
REQ-010 Port busy, output, 1 bit: high while a run is in progress.
REQ-011 Port init_done, output, 1 bit: sticky flag set when a run completes successfully.
REQ-012 Port err, output, 1 bit: sticky flag set when a run aborts on timeout.
REQ-013 Port idx, output, 4 bits: index of the current table entry.

Function
REQ-014 The FSM SHALL have exactly the states IDLE, LOAD, ISSUE, WAIT, GAP, DONE and ERR, all registered.
REQ-015 In IDLE, DONE or ERR, start=1 SHALL move the FSM to LOAD, set idx=0, and clear init_done and err.
REQ-016 LOAD SHALL register cyc_addr and cyc_data from table[idx] and go to ISSUE on the next clock.
REQ-017 ISSUE SHALL assert cyc_en, clear the timeout counter and go to WAIT; cyc_en SHALL therefore first be high 2 clocks after start is sampled.
REQ-018 WAIT SHALL keep cyc_en=1 and increment the 8-bit timeout counter by one per clock.
REQ-019 In WAIT, cyc_done=1 SHALL move the FSM to GAP; cyc_done has priority over timeout when both occur in the same clock.
REQ-020 In WAIT, a timeout counter equal to TIMEOUT-1 without cyc_done SHALL move the FSM to ERR.
REQ-021 GAP SHALL drive cyc_en=0 for exactly GAP clocks.
REQ-022 At the end of GAP, if idx equals the last table index the FSM SHALL go to DONE; otherwise idx SHALL increment and the FSM SHALL go to LOAD.
REQ-023 DONE SHALL set init_done=1 and busy=0; ERR SHALL set err=1 and busy=0; cyc_en SHALL be 0 in both states.
REQ-024 busy SHALL be 1 exactly in LOAD, ISSUE, WAIT and GAP.
REQ-025 start while busy=1 SHALL be ignored, and cyc_done outside WAIT SHALL be ignored.
REQ-026 cyc_addr and cyc_data SHALL stay stable from LOAD until the next LOAD.
REQ-027 The base table, in order, SHALL be: (0x02,0x10), (0x02,0x00), (0x10,0xD2), (0x00,0x00); base length 4, last index 3.

Reset
REQ-028 While reset=0, the FSM SHALL be IDLE and idx, the timeout counter, the gap counter, cyc_en, cyc_addr, cyc_data, busy, init_done and err SHALL all be 0.
REQ-029 Reset asserted mid-run SHALL drop cyc_en asynchronously, and no write SHALL resume after reset is released.

Configuration
REQ-030 With macro RTC_CLEAR_TIME_EN defined, the table SHALL append six entries (0x21..0x26, 0x00) after the base entries, giving last index 9.
REQ-031 Without RTC_CLEAR_TIME_EN, the table SHALL hold only the 4 base entries.

Verification
REQ-032 Reset, then start pulse with cyc_done returned 5 clocks after each cyc_en rise -> 4 writes (02/10, 02/00, 10/D2, 00/00), cyc_en low for 2 clocks between writes, then init_done=1 and busy=0.
REQ-033 cyc_done never returned -> cyc_en high for 64 clocks, then err=1, busy=0, cyc_en=0, idx=0.
REQ-034 start pulsed again during the third write -> ignored; the sequence completes with exactly 4 writes.
REQ-035 reset driven low during WAIT of idx=1 -> all outputs 0 immediately; a start after release restarts at idx=0 with cyc_addr=0x02, cyc_data=0x10.
REQ-036 cyc_done in the same clock as the timeout limit -> GAP is taken and err stays 0.
REQ-037 Build with RTC_CLEAR_TIME_EN -> 10 writes, the last six to addresses 0x21..0x26 with data 0x00, then init_done=1.
